// File: rtl/stream_pkg.sv
// stream_pkg: shared beat type, sizing constants and popcount helper for the stream datapath
package stream_pkg;
  localparam int BYTES_PER_BEAT = 64;
  localparam int CNT_W = 7;
  typedef struct packed {
    logic [8*BYTES_PER_BEAT-1:0] data;
    logic [BYTES_PER_BEAT-1:0]   keep;
    logic                        last;
    logic                        last_transfer_flag;
    logic [CNT_W-1:0]            count;
  } beat_t;
  function automatic logic [CNT_W-1:0] popcount_64(input logic [63:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/compact_shift_stage.sv
// compact_shift_stage: one registered log-shifter level moving bytes down by 2^SHIFT_BIT lanes
module compact_shift_stage #(
  parameter int BYTES = 64,
  parameter int HW = 6,
  parameter int SW = 10,
  parameter int SHIFT_BIT = 0
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic                enable,
  input  logic [BYTES*8-1:0]  data_in,
  input  logic [BYTES-1:0]    lv_in,
  input  logic [BYTES*HW-1:0] h_in,
  input  logic [SW-1:0]       side_in,
  output logic [BYTES*8-1:0]  data_out,
  output logic [BYTES-1:0]    lv_out,
  output logic [BYTES*HW-1:0] h_out,
  output logic [SW-1:0]       side_out
);
  localparam int S = 1 << SHIFT_BIT;
  logic [BYTES-1:0]    mv, st;
  logic [BYTES*8-1:0]  mv_d, st_d;
  logic [BYTES*HW-1:0] mv_h, st_h;
  // split lanes into those moving this level and those staying put
  always_comb begin
    mv = '0;
    st = '0;
    mv_d = '0;
    st_d = '0;
    mv_h = '0;
    st_h = '0;
    for (int i = 0; i < BYTES; i++) begin
      mv[i] = lv_in[i] & h_in[HW*i+SHIFT_BIT];
      st[i] = lv_in[i] & ~h_in[HW*i+SHIFT_BIT];
      mv_d[8*i +: 8] = mv[i] ? data_in[8*i +: 8] : 8'h00;
      st_d[8*i +: 8] = st[i] ? data_in[8*i +: 8] : 8'h00;
      mv_h[HW*i +: HW] = mv[i] ? h_in[HW*i +: HW] : '0;
      st_h[HW*i +: HW] = st[i] ? h_in[HW*i +: HW] : '0;
    end
  end
  // merge shifted and stationary lanes; holes never collide so OR is enough
  always_ff @(posedge aclk) begin
    if (reset) begin
      data_out <= '0;
      lv_out   <= '0;
      h_out    <= '0;
      side_out <= '0;
    end else if (enable) begin
      data_out <= st_d | (mv_d >> (8*S));
      lv_out   <= st | (mv >> S);
      h_out    <= st_h | (mv_h >> (HW*S));
      side_out <= side_in;
    end
  end
endmodule

// File: rtl/stream_keep_compactor.sv
// stream_keep_compactor: pipelined compaction of sparse-keep beats into contiguous low lanes
module stream_keep_compactor
  import stream_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter bit DROP_EMPTY = 1'b1,
  parameter int CNT_W = $clog2(WIDTH/8)+1
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH/8-1:0] keep_in,
  input  logic               valid_in,
  input  logic               last_in,
  input  logic               last_transfer_flag_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [WIDTH/8-1:0] keep_out,
  output logic               valid_out,
  output logic               last_out,
  output logic               last_transfer_flag_out,
  output logic [CNT_W-1:0]   count_out
);
  localparam int BYTES = WIDTH/8;
  localparam int HW = $clog2(BYTES);
  localparam int SW = CNT_W + 3;
  logic [WIDTH-1:0]    d_s  [HW+1];
  logic [BYTES-1:0]    lv_s [HW+1];
  logic [BYTES*HW-1:0] h_s  [HW+1];
  logic [SW-1:0]       sb_s [HW+1];
  logic [WIDTH-1:0]    d_in, d0;
  logic [BYTES*HW-1:0] h_in, h0;
  logic [BYTES-1:0]    lv0;
  logic [SW-1:0]       sb0;
  logic [HW:0]         kept;
  logic [CNT_W-1:0]    cnt_in, cnt_l;
  logic                v_l, l_l, t_l;
  logic                unused_h;
  assign cnt_in = CNT_W'(popcount_64(64'(keep_in)));
  // zero dropped bytes and give each lane its hole count (lanes below it with keep=0)
  always_comb begin
    d_in = '0;
    h_in = '0;
    kept = '0;
    for (int i = 0; i < BYTES; i++) begin
      d_in[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
      h_in[HW*i +: HW] = HW'(i - int'(kept));
      kept = kept + (HW+1)'(keep_in[i]);
    end
  end
  // stage 0: capture the beat; idle slots load as all-zero bubbles
  always_ff @(posedge aclk) begin
    if (reset) begin
      d0  <= '0;
      lv0 <= '0;
      h0  <= '0;
      sb0 <= '0;
    end else if (enable) begin
      d0  <= valid_in ? d_in : '0;
      lv0 <= valid_in ? keep_in : '0;
      h0  <= valid_in ? h_in : '0;
      sb0 <= valid_in ? {1'b1, last_in, last_transfer_flag_in, cnt_in} : '0;
    end
  end
  assign d_s[0]  = d0;
  assign lv_s[0] = lv0;
  assign h_s[0]  = h0;
  assign sb_s[0] = sb0;
  for (genvar k = 0; k < HW; k++) begin : g_shift
    compact_shift_stage #(
      .BYTES(BYTES),
      .HW(HW),
      .SW(SW),
      .SHIFT_BIT(k)
    ) u_stage (
      .aclk(aclk),
      .reset(reset),
      .enable(enable),
      .data_in(d_s[k]),
      .lv_in(lv_s[k]),
      .h_in(h_s[k]),
      .side_in(sb_s[k]),
      .data_out(d_s[k+1]),
      .lv_out(lv_s[k+1]),
      .h_out(h_s[k+1]),
      .side_out(sb_s[k+1])
    );
  end
  assign {v_l, l_l, t_l, cnt_l} = sb_s[HW];
  assign unused_h = ^h_s[HW];
  // output stage: empty non-last beats become bubbles when dropping is enabled
  always_ff @(posedge aclk) begin
    if (reset) begin
      data_out               <= '0;
      keep_out               <= '0;
      valid_out              <= 1'b0;
      last_out               <= 1'b0;
      last_transfer_flag_out <= 1'b0;
      count_out              <= '0;
    end else if (enable) begin
      data_out               <= d_s[HW];
      keep_out               <= lv_s[HW];
      valid_out              <= v_l & (!DROP_EMPTY | (|cnt_l) | l_l);
      last_out               <= l_l;
      last_transfer_flag_out <= t_l;
      count_out              <= cnt_l;
    end
  end
endmodule

// File: tb/tb_stream_keep_compactor.sv
// tb_stream_keep_compactor: scoreboard bench for the keep compactor
module tb_stream_keep_compactor;
  import stream_pkg::*;
  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic [511:0] data_in = '0;
  logic [63:0]  keep_in = '0;
  logic         valid_in = 1'b0;
  logic         last_in = 1'b0;
  logic         ltf_in = 1'b0;
  logic [511:0] data_out;
  logic [63:0]  keep_out;
  logic         valid_out;
  logic         last_out;
  logic         ltf_out;
  logic [6:0]   count_out;
  int           passed = 0;
  int           total = 0;
  int           ecyc = 0;
  bit           adv = 1'b0;
  beat_t        exp_q[$];
  int           lat_q[$];
  beat_t        got;
  int           got_lat;

  stream_keep_compactor dut (
    .aclk(aclk),
    .reset(reset),
    .enable(enable),
    .data_in(data_in),
    .keep_in(keep_in),
    .valid_in(valid_in),
    .last_in(last_in),
    .last_transfer_flag_in(ltf_in),
    .data_out(data_out),
    .keep_out(keep_out),
    .valid_out(valid_out),
    .last_out(last_out),
    .last_transfer_flag_out(ltf_out),
    .count_out(count_out)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    adv = enable && !reset;
    if (enable) ecyc++;
  end

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  always @(negedge aclk) begin
    if (adv && valid_out) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got valid_out=1 keep=%h want no beat", keep_out);
      end else begin
        got = exp_q.pop_front();
        got_lat = lat_q.pop_front();
        check("data", data_out, got.data);
        check("keep", 512'(keep_out), 512'(got.keep));
        check("count", 512'(count_out), 512'(got.count));
        check("last", 512'(last_out), 512'(got.last));
        check("ltf", 512'(ltf_out), 512'(got.last_transfer_flag));
        check("latency", 512'(ecyc), 512'(got_lat));
      end
    end
  end

  function automatic beat_t model(input logic [511:0] d, input logic [63:0] k, input logic l, input logic t);
    beat_t b;
    int n;
    b = '0;
    n = 0;
    for (int i = 0; i < 64; i++)
      if (k[i]) begin
        b.data[8*n +: 8] = d[8*i +: 8];
        n++;
      end
    b.keep = (n == 64) ? '1 : (64'd1 << n) - 64'd1;
    b.count = 7'(n);
    b.last = l;
    b.last_transfer_flag = t;
    return b;
  endfunction

  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l, input logic t,
                      input beat_t e, input bit expect_out);
    @(negedge aclk);
    data_in = d;
    keep_in = k;
    last_in = l;
    ltf_in = t;
    valid_in = 1'b1;
    if (expect_out) begin
      exp_q.push_back(e);
      lat_q.push_back(ecyc + 8);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      valid_in = 1'b0;
      data_in = '0;
      keep_in = '0;
      last_in = 1'b0;
      ltf_in = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      idle(1);
      w++;
    end
    idle(3);
    check(nm, 512'(exp_q.size()), 512'(0));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_data"}, data_out, '0);
    check({nm, "_keep"}, 512'(keep_out), '0);
    check({nm, "_ctl"}, 512'({valid_out, last_out, ltf_out, count_out}), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [511:0] d, d2;
    logic [63:0]  k;
    beat_t        e;
    logic [511:0] sd;
    logic [63:0]  sk;
    logic [9:0]   sc;
    // reset with a beat presented alongside: it must be discarded
    @(negedge aclk);
    valid_in = 1'b1;
    keep_in = '1;
    data_in = {16{32'hDEADBEEF}};
    @(negedge aclk);
    check_zero("reset");
    reset = 1'b0;
    valid_in = 1'b0;
    // all ones: identity
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
    e = '0;
    e.data = d;
    e.keep = '1;
    e.count = 7'd64;
    send(d, '1, 1'b0, 1'b0, e, 1'b1);
    // first and last byte only
    d = '0;
    for (int i = 1; i < 63; i++) d[8*i +: 8] = 8'h11;
    d[7:0] = 8'hAA;
    d[511:504] = 8'h55;
    e = '0;
    e.data = 512'h55AA;
    e.keep = 64'h3;
    e.count = 7'd2;
    e.last = 1'b1;
    send(d, 64'h8000_0000_0000_0001, 1'b1, 1'b0, e, 1'b1);
    // odd lanes only
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
    d2 = '0;
    for (int j = 0; j < 32; j++) d2[8*j +: 8] = 8'(2*j+1);
    e = '0;
    e.data = d2;
    e.keep = 64'h0000_0000_FFFF_FFFF;
    e.count = 7'd32;
    send(d, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, e, 1'b1);
    // single byte in the top lane
    d = '0;
    d[511:504] = 8'h5A;
    e = '0;
    e.data = 512'h5A;
    e.keep = 64'h1;
    e.count = 7'd1;
    send(d, 64'h8000_0000_0000_0000, 1'b0, 1'b0, e, 1'b1);
    // empty non-last beat is dropped; empty last beat is kept
    e = '0;
    send({16{32'h12345678}}, '0, 1'b0, 1'b0, e, 1'b0);
    e.last = 1'b1;
    e.last_transfer_flag = 1'b1;
    send({16{32'h9ABCDEF0}}, '0, 1'b1, 1'b1, e, 1'b1);
    drain("drain_directed");
    // random stream with a three-cycle stall in the middle
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      k = (n % 4 == 0) ? 64'h0 : (n % 4 == 1) ? {$urandom, $urandom} : {$urandom, $urandom} & {$urandom, $urandom};
      e = model(d, k, n[0], n % 5 == 0);
      send(d, k, n[0], n % 5 == 0, e, (e.count != 0) || n[0]);
      if (n == 9) begin
        @(negedge aclk);
        enable = 1'b0;
        valid_in = 1'b1;
        keep_in = '1;
        sd = data_out;
        sk = keep_out;
        sc = {valid_out, last_out, ltf_out, count_out};
        for (int s = 0; s < 3; s++) begin
          @(negedge aclk);
          check("stall_data", data_out, sd);
          check("stall_keep", 512'(keep_out), 512'(sk));
          check("stall_ctl", 512'({valid_out, last_out, ltf_out, count_out}), 512'(sc));
        end
        enable = 1'b1;
        valid_in = 1'b0;
      end
    end
    drain("drain_stream");
    // reset with four beats in flight
    for (int n = 0; n < 4; n++) begin
      d = {16{$urandom}};
      e = model(d, '1, 1'b1, 1'b0);
      send(d, '1, 1'b1, 1'b0, e, 1'b1);
    end
    @(negedge aclk);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge aclk);
    check_zero("midreset");
    reset = 1'b0;
    valid_in = 1'b0;
    idle(12);
    // recovery after reset
    d = {16{32'hC0FFEE11}};
    k = 64'h0F0F_0000_0000_F0F0;
    e = model(d, k, 1'b1, 1'b1);
    send(d, k, 1'b1, 1'b1, e, 1'b1);
    drain("drain_final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
